// File: rtl/xor_checker.sv
// xor_checker: response monitor for an xor1 gate; checks y against a ^ b,
// counts vectors and mismatches, tracks input coverage, registers a verdict.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin (or restart) a run
//   vld, a, b, y        vector strobe, gate inputs and gate output under check
//   busy, done          high in RUN / high in DONE
//   pass                verdict, meaningful while done = 1
//   err                 one-cycle pulse per mismatching vector
//   vec_cnt, err_cnt    accepted vectors / mismatches in the current run
//   cov                 bit {a,b} set once that combination was accepted
//   first_err_vld/_vec  capture of the first mismatching {a,b}
module xor_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vld,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic             first_err_vld,
    output logic [1:0]       first_err_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_VECTORS);

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             err_q;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [3:0]       cov_q;
    logic             fev_q;
    logic [1:0]       fe_q;

    logic [1:0]       idx;
    logic             mis;
    logic [CNT_W-1:0] vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_d;
    logic [3:0]       cov_d;

    // Counter/coverage values as they stand after accepting the current
    // vector; the verdict on the final vector is formed from these so the
    // last vector is included.
    always_comb begin
        idx       = {a, b};
        mis       = (y != (a ^ b));
        vec_cnt_d = vec_cnt_q + 1'b1;
        err_cnt_d = mis ? err_cnt_q + 1'b1 : err_cnt_q;
        cov_d     = cov_q | (4'b0001 << idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
            cov_q     <= 4'b0000;
            fev_q     <= 1'b0;
            fe_q      <= 2'b00;
        end else begin
            err_q <= 1'b0;
            if (start) begin
                // start wins over vld in every state; the vector is dropped
                state_q   <= RUN;
                busy_q    <= 1'b1;
                done_q    <= 1'b0;
                pass_q    <= 1'b0;
                vec_cnt_q <= '0;
                err_cnt_q <= '0;
                cov_q     <= 4'b0000;
                fev_q     <= 1'b0;
                fe_q      <= 2'b00;
            end else begin
                case (state_q)
                    RUN: begin
                        if (vld) begin
                            vec_cnt_q <= vec_cnt_d;
                            err_cnt_q <= err_cnt_d;
                            cov_q     <= cov_d;
                            err_q     <= mis;
                            if (mis && !fev_q) begin
                                fev_q <= 1'b1;
                                fe_q  <= idx;
                            end
                            if (vec_cnt_d == LAST) begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                pass_q  <= (err_cnt_d == '0) &&
                                           (cov_d == 4'b1111);
                            end
                        end
                    end
                    DONE:    state_q <= DONE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err           = err_q;
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign cov           = cov_q;
    assign first_err_vld = fev_q;
    assign first_err_vec = fe_q;

endmodule

// File: tb/tb_xor_checker.sv
// tb_xor_checker: scenario tests plus a randomized run for xor_checker,
// checked against a run-history reference model.
module tb_xor_checker;

    localparam int NV = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          vld = 1'b0;
    logic          a = 1'b0;
    logic          b = 1'b0;
    logic          y = 1'b0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          err;
    logic [CW-1:0] vec_cnt;
    logic [CW-1:0] err_cnt;
    logic [3:0]    cov;
    logic          first_err_vld;
    logic [1:0]    first_err_vec;

    always #5 clk = ~clk;

    xor_checker #(.NUM_VECTORS(NV), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
        .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .err(err),
        .vec_cnt(vec_cnt), .err_cnt(err_cnt), .cov(cov),
        .first_err_vld(first_err_vld), .first_err_vec(first_err_vec)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 run, 2 done; hist holds the
    // accepted {a,b,y} of the current run, everything else derives from it.
    int         phase = 0;
    logic [2:0] hist[$];
    logic       m_err = 1'b0;

    function automatic logic bad(logic [2:0] v);
        return v[0] != (v[2] ^ v[1]);
    endfunction

    function automatic logic [26:0] expv();
        int         ne = 0;
        logic [3:0] c = 4'b0;
        logic       fv = 1'b0;
        logic [1:0] fe = 2'b0;
        logic       p;
        foreach (hist[i]) begin
            c[hist[i][2:1]] = 1'b1;
            if (bad(hist[i])) begin
                ne++;
                if (!fv) begin
                    fv = 1'b1;
                    fe = hist[i][2:1];
                end
            end
        end
        p = (phase == 2) && (ne == 0) && (c == 4'hF);
        return {phase == 1, phase == 2, p, m_err,
                CW'(hist.size()), CW'(ne), c, fv, fe};
    endfunction

    function automatic logic [26:0] obs();
        return {busy, done, pass, err, vec_cnt, err_cnt, cov,
                first_err_vld, first_err_vec};
    endfunction

    task automatic step(input logic r, input logic st, input logic v,
                        input logic [2:0] aby);
        rst_n = r;
        start = st;
        vld = v;
        {a, b, y} = aby;
        @(posedge clk);
        if (!r) begin
            phase = 0;
            hist.delete();
            m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (st) begin
                phase = 1;
                hist.delete();
            end else if (phase == 1 && v) begin
                hist.push_back(aby);
                m_err = bad(aby);
                if (hist.size() == NV) phase = 2;
            end
        end
        #1;
        start = 1'b0;
        vld = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b1, 3'b111);
        step(1'b0, 1'b0, 1'b0, 3'b000);
        checks++;
        if (obs() !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", obs());
        end
    endtask

    task automatic test_good_sweep();
        logic [2:0] g[4] = '{3'b000, 3'b011, 3'b101, 3'b110};
        logic       seen = 1'b0;
        step(1'b1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, g[i]);
            seen |= err;
        end
        checks++;
        if ({seen, done, pass, vec_cnt, err_cnt, cov} !==
            {1'b0, 1'b1, 1'b1, CW'(4), CW'(0), 4'hF}) begin
            errors++;
            $display("FAIL good_sweep got d%b p%b v%0d e%0d c%b err%b",
                     done, pass, vec_cnt, err_cnt, cov, seen);
        end
        checks++;
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL good_model got %h exp %h", obs(), expv());
        end
    endtask

    task automatic test_stuck0();
        logic [2:0] g[4] = '{3'b000, 3'b010, 3'b100, 3'b110};
        logic [3:0] ep = 4'b0110;
        step(1'b1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, g[i]);
            checks++;
            if (err !== ep[i]) begin
                errors++;
                $display("FAIL stuck0_err%0d got %b exp %b", i, err, ep[i]);
            end
        end
        checks++;
        if ({done, pass, err_cnt, first_err_vld, first_err_vec} !==
            {1'b1, 1'b0, CW'(2), 1'b1, 2'b01}) begin
            errors++;
            $display("FAIL stuck0_final got d%b p%b e%0d fv%b fe%b",
                     done, pass, err_cnt, first_err_vld, first_err_vec);
        end
    endtask

    task automatic test_missing_cov();
        logic [2:0] g[4] = '{3'b000, 3'b011, 3'b011, 3'b101};
        step(1'b1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, g[i]);
        checks++;
        if ({done, pass, err_cnt, cov} !==
            {1'b1, 1'b0, CW'(0), 4'b0111}) begin
            errors++;
            $display("FAIL missing_cov got d%b p%b e%0d c%b",
                     done, pass, err_cnt, cov);
        end
    endtask

    task automatic test_gaps();
        logic [2:0] g[4] = '{3'b110, 3'b101, 3'b011, 3'b000};
        step(1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b011);
        step(1'b1, 1'b0, 1'b1, 3'b111);
        checks++;
        if ({busy, vec_cnt} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL idle_vld got b%b v%0d exp b0 v0", busy, vec_cnt);
        end
        step(1'b1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, g[i]);
            if (i < 3)
                for (int k = 0; k < 3; k++)
                    step(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
        end
        checks++;
        if ({done, pass} !== 2'b11) begin
            errors++;
            $display("FAIL gaps_pass got d%b p%b exp d1 p1", done, pass);
        end
        step(1'b1, 1'b0, 1'b1, 3'b111);
        checks++;
        if ({done, vec_cnt, err_cnt} !== {1'b1, CW'(4), CW'(0)}) begin
            errors++;
            $display("FAIL done_vld got d%b v%0d e%0d exp d1 v4 e0",
                     done, vec_cnt, err_cnt);
        end
    endtask

    task automatic test_restart();
        logic [2:0] g[4] = '{3'b000, 3'b011, 3'b101, 3'b110};
        step(1'b1, 1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b010);
        step(1'b1, 1'b0, 1'b1, 3'b100);
        step(1'b1, 1'b1, 1'b1, 3'b111);
        checks++;
        if ({busy, vec_cnt, err_cnt, first_err_vld} !==
            {1'b1, CW'(0), CW'(0), 1'b0}) begin
            errors++;
            $display("FAIL restart got b%b v%0d e%0d fv%b",
                     busy, vec_cnt, err_cnt, first_err_vld);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, g[i]);
        checks++;
        if ({done, pass} !== 2'b11) begin
            errors++;
            $display("FAIL restart_pass got d%b p%b exp d1 p1", done, pass);
        end
    endtask

    task automatic test_reset_midrun();
        step(1'b1, 1'b1, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b010);
        step(1'b1, 1'b0, 1'b1, 3'b101);
        step(1'b0, 1'b0, 1'b1, 3'b110);
        checks++;
        if (obs() !== 27'd0) begin
            errors++;
            $display("FAIL reset_midrun got %h exp 0", obs());
        end
    endtask

    task automatic test_final_mismatch();
        logic [2:0] g[3] = '{3'b000, 3'b011, 3'b101};
        step(1'b1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, g[i]);
        checks++;
        if ({err, done} !== 2'b00) begin
            errors++;
            $display("FAIL final_pre got err%b d%b exp 00", err, done);
        end
        step(1'b1, 1'b0, 1'b1, 3'b111);
        checks++;
        if ({err, done, pass, err_cnt, first_err_vec} !==
            {1'b1, 1'b1, 1'b0, CW'(1), 2'b11}) begin
            errors++;
            $display("FAIL final_mis got err%b d%b p%b e%0d fe%b",
                     err, done, pass, err_cnt, first_err_vec);
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       st;
        logic       v;
        logic [1:0] ab;
        logic       flip;
        int         bad_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 199) != 0);
            st   = ($urandom_range(0, 29) == 0);
            v    = ($urandom_range(0, 2) != 0);
            ab   = 2'($urandom_range(0, 3));
            flip = ($urandom_range(0, 9) == 0);
            step(r, st, v, {ab, (ab[1] ^ ab[0]) ^ flip});
            checks++;
            if (obs() !== expv()) begin
                errors++;
                bad_cnt++;
                if (bad_cnt <= 10)
                    $display("FAIL random_cyc%0d got %h exp %h",
                             n, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_stuck0();
        test_missing_cov();
        test_gaps();
        test_restart();
        test_reset_midrun();
        test_final_mismatch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_checker.md
# xor_checker

Self-checking response monitor for the `xor1` gate; it is the receiving end of the stimulus sweep that drives the gate. It samples each presented vector `{a, b}` and the gate output `y`, and compares `y` against `a ^ b`. It also counts vectors and mismatches, tracks which of the four input combinations were exercised, and reports a registered pass/fail verdict once the programmed number of vectors has been seen. It sits beside the `xor1` instance and replaces print-and-inspect checking with a hardware verdict.

## Interface
- `NUM_VECTORS`, 4: number of accepted vectors that completes a run; legal range is 1 to 2^CNT_W−1.
- `CNT_W`, 8: width of the vector and error counters.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: begins a new run; sampled on the rising edge.
- `vld` input 1: a valid vector is present on `a`, `b`, `y` this cycle.
- `a` input 1: gate input A as driven.
- `b` input 1: gate input B as driven.
- `y` input 1: gate output under check.
- `busy` output 1: high while in RUN.
- `done` output 1: high while in DONE.
- `pass` output 1: verdict; meaningful only while `done` is 1.
- `err` output 1: one-cycle pulse per mismatching vector.
- `vec_cnt` output CNT_W: number of vectors accepted in the current run.
- `err_cnt` output CNT_W: number of mismatches in the current run.
- `cov` output 4: bit `{a,b}` is set once that combination has been accepted.
- `first_err_vld` output 1: at least one mismatch has occurred this run.
- `first_err_vec` output 2: `{a,b}` of the first mismatching vector.

## Operation
- **States:** IDLE, RUN, DONE.
  - Reset enters IDLE.
  - At reset, all outputs are 0. This includes `pass`, `cov` = 4'b0000 and `first_err_vec` = 2'b00.
- **IDLE:**
  - `vld` is ignored.
  - `start` = 1 moves to RUN and clears `vec_cnt`, `err_cnt`, `cov`, `first_err_vld`, `first_err_vec` and `pass`.
- **RUN:** every edge with `vld` = 1 accepts one vector, and does the following:
  - `vec_cnt` += 1.
  - `cov[{a,b}]` is set to 1.
  - Mismatch is defined as `y != (a ^ b)`. On a mismatch:
    - `err_cnt` += 1.
    - `err` pulses.
    - If `first_err_vld` = 0, capture `first_err_vec` = `{a,b}` and set `first_err_vld`.
  - The acceptance that makes `vec_cnt` == `NUM_VECTORS` moves to DONE.
    - That final vector is fully counted and checked before the verdict is formed.
  - `vld` = 0 leaves the state unchanged. Gaps between vectors of any length are legal.
- **DONE:**
  - `pass` = (final `err_cnt` == 0) AND (`cov` == 4'b1111).
  - The verdict includes the last vector.
  - `vld` is ignored. Counters, `cov` and the first-error capture hold.
  - `start` = 1 clears everything and moves back to RUN.
- **Simultaneous events:**
  - `start` = 1 in RUN restarts the run: all run state is cleared, the state stays RUN, and any `vld` in the same cycle is discarded.
  - `start` together with `vld` in IDLE or DONE: the vector is discarded.
  - `rst_n` = 0 overrides everything in every state, including mid-run, and returns to IDLE with all outputs 0.
- **Width rules:**
  - The comparison is exact 1-bit.
  - `err_cnt` ≤ `vec_cnt` ≤ `NUM_VECTORS`, so neither counter wraps.
  - `first_err_vec` bit 1 is `a`, bit 0 is `b`.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- A vector is sampled at edge k:
  - `vec_cnt`, `err_cnt`, `cov` and the first-error fields show the update after edge k.
  - `err` is high for exactly the cycle following edge k, and low again after edge k+1 unless the next vector also mismatches.
- The final vector accepted at edge k gives `busy` = 0, `done` = 1 and `pass` valid, all after edge k.
  - Latency from the last vector to the verdict is 1 cycle.
- `start` at edge k gives `busy` = 1 with cleared counters after edge k. The first vector can be accepted at edge k+1.
- Back-to-back vectors at one per cycle are sustained indefinitely.

## Test plan
- **Good gate, full sweep.** Reset, then `start`, then vectors {0,0,0}, {0,1,1}, {1,0,1}, {1,1,0} on consecutive cycles.
  - Expect `done` = 1 one cycle after the 4th vector.
  - Expect `pass` = 1, `vec_cnt` = 4, `err_cnt` = 0, `cov` = 4'b1111, and `err` never high.
- **Stuck-at-0 output.** Same sweep with `y` held at 0.
  - Expect `err` pulses after the 2nd and 3rd vectors.
  - Expect `err_cnt` = 2, `first_err_vec` = 2'b01, `first_err_vld` = 1 and `pass` = 0.
- **Missing coverage.** `start`, then {0,0,0}, {0,1,1}, {0,1,1}, {1,0,1}.
  - Expect `done` = 1, `err_cnt` = 0, `cov` = 4'b0111 and `pass` = 0.
- **Gaps and ignored vectors.**
  - Present `vld` in IDLE before `start`: expect `vec_cnt` to stay 0.
  - After `start`, present the 4 good vectors with 3 idle cycles between each: expect `pass` = 1.
  - Present a further `vld` in DONE: expect `vec_cnt` to stay 4.
- **Restart and reset mid-run.**
  - After 2 mismatching vectors, assert `start`: expect `err_cnt` = 0, `first_err_vld` = 0 and `busy` = 1, then a clean sweep gives `pass` = 1.
  - In a later run, pull `rst_n` low after 3 vectors: expect IDLE and all outputs 0 on the next edge.
- **Final-vector mismatch.** Good first 3 vectors, 4th is {1,1,1}.
  - Expect `err` and `done` to rise together one cycle later.
  - Expect `err_cnt` = 1, `first_err_vec` = 2'b11 and `pass` = 0.
